uart_rx_ctrl: RTL

// - Frame-sequencing controller for the UART receiver: detects the start edge and steps through START, DATA, PARITY and STOP bit slots.
// - Owns the oversampling edge/bit counters and drives the enables of the sampler, deserializer and start/parity/stop checkers.
// - Collects their error results, then issues a one-cycle data_valid or error pulse per frame.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_ctrl_if.sv | 39 +++
 rtl/rx_edge_bit_counter.sv | 46 ++++
 rtl/uart_rx_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

  localparam int unsigned DefDataWidth    = 8;
  localparam int unsigned DefPrescaleBits = 6;

  localparam int unsigned PrescaleX8  = 8;
  localparam int unsigned PrescaleX16 = 16;
  localparam int unsigned PrescaleX32 = 32;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StChk
  } state_e;

  // States in which the oversampling counters advance.
  function automatic logic is_run(state_e s);
    return (s == StStart) || (s == StData) || (s == StParity) || (s == StStop);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Line, configuration, checker-result and enable signals of the receive controller.
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PRESCALE_BITS = 6
) ();

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 3);

  logic                     RX_IN;
  logic                     PAR_EN;
  logic                     PAR_TYP;
  logic [PRESCALE_BITS-1:0] Prescale;
  logic                     strt_glitch;
  logic                     par_err;
  logic                     stp_err;
  logic [PRESCALE_BITS-1:0] edge_cnt;
  logic [BitCntW-1:0]       bit_cnt;
  logic                     par_typ_q;
  logic                     dat_samp_en;
  logic                     deser_en;
  logic                     strt_chk_en;
  logic                     par_chk_en;
  logic                     stp_chk_en;
  logic                     data_valid;
  logic                     frame_err;

  modport master (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, par_typ_q, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, frame_err
  );

  modport slave (
    output RX_IN, PAR_EN, PAR_TYP, Prescale, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, par_typ_q, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, frame_err
  );

endinterface

// File: rtl/rx_edge_bit_counter.sv
// Oversample (edge) and slot (bit) counters; both held at zero while disabled.
module rx_edge_bit_counter #(
  parameter int unsigned PRESCALE_BITS = 6,
  parameter int unsigned BIT_CNT_W     = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     enable,
  input  logic [PRESCALE_BITS-1:0] prescale,
  output logic [PRESCALE_BITS-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]     bit_cnt,
  output logic                     slot_end
);

  logic [PRESCALE_BITS-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;

  assign slot_end = (edge_cnt_q == prescale - PRESCALE_BITS'(1));

  always_comb begin
    edge_cnt_d = '0;
    bit_cnt_d  = '0;
    if (enable) begin
      if (slot_end) begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      end else begin
        edge_cnt_d = edge_cnt_q + PRESCALE_BITS'(1);
        bit_cnt_d  = bit_cnt_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: walks START/DATA/PARITY/STOP slots, gates the
// datapath enables and reports one data_valid or frame_err pulse per frame.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DefDataWidth,
  parameter int unsigned PRESCALE_BITS = DefPrescaleBits
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_ctrl_if.master bus
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 3);

  state_e                   state_q, state_d;
  logic                     err_q, err_d;
  logic                     par_en_q, par_typ_q;
  logic [PRESCALE_BITS-1:0] prescale_q;
  logic                     latch_cfg;
  logic                     cnt_en, slot_end, first_cycle;
  logic [PRESCALE_BITS-1:0] edge_cnt;
  logic [BitCntW-1:0]       bit_cnt;
  logic                     deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic                     data_valid, frame_err;

  // Counters only keep running while we stay inside the frame; any exit clears them.
  assign cnt_en      = is_run(state_q) && is_run(state_d);
  assign first_cycle = (edge_cnt == '0);

  rx_edge_bit_counter #(
    .PRESCALE_BITS (PRESCALE_BITS),
    .BIT_CNT_W     (BitCntW)
  ) u_counter (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (cnt_en),
    .prescale (prescale_q),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .slot_end (slot_end)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    latch_cfg   = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    frame_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        err_d = 1'b0;
        if (!bus.RX_IN) begin
          state_d   = StStart;
          latch_cfg = 1'b1;
        end
      end
      StStart: begin
        strt_chk_en = 1'b1;
        if (slot_end) state_d = StData;
      end
      StData: begin
        // Start checker result lands one cycle after the START slot closes.
        if (first_cycle && (bit_cnt == BitCntW'(1)) && bus.strt_glitch) begin
          state_d = StIdle;
        end else if (slot_end) begin
          deser_en = 1'b1;
          if (bit_cnt == BitCntW'(DATA_WIDTH)) state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        par_chk_en = 1'b1;
        if (slot_end) state_d = StStop;
      end
      StStop: begin
        stp_chk_en = 1'b1;
        if (first_cycle && bus.par_err) err_d = 1'b1;
        if (slot_end) state_d = StChk;
      end
      StChk: begin
        if (err_q || bus.stp_err) frame_err = 1'b1;
        else                      data_valid = 1'b1;
        err_d = 1'b0;
        if (!bus.RX_IN) begin
          state_d   = StStart;
          latch_cfg = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      err_q      <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (latch_cfg) begin
        par_en_q   <= bus.PAR_EN;
        par_typ_q  <= bus.PAR_TYP;
        prescale_q <= bus.Prescale;
      end
    end
  end

  assign bus.edge_cnt    = edge_cnt;
  assign bus.bit_cnt     = bit_cnt;
  assign bus.par_typ_q   = par_typ_q;
  assign bus.dat_samp_en = is_run(state_q);
  assign bus.deser_en    = deser_en;
  assign bus.strt_chk_en = strt_chk_en;
  assign bus.par_chk_en  = par_chk_en;
  assign bus.stp_chk_en  = stp_chk_en;
  assign bus.data_valid  = data_valid;
  assign bus.frame_err   = frame_err;

endmodule
